// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and the JEDEC byte selector
// for the SPI flash responder.
package spi_flash_pkg;

    localparam int unsigned ADDR_W    = 24;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 5;

    localparam logic [BYTE_W-1:0] OP_READ = 8'h03;
    localparam logic [BYTE_W-1:0] OP_RDID = 8'h9F;
    localparam logic [BYTE_W-1:0] OP_RDSR = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ID,
        ST_STAT,
        ST_IGNORE
    } state_t;

    // Byte idx of the identification word, MSB first; past the end reads zero.
    function automatic logic [BYTE_W-1:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = id[23:16];
            2'd1:    id_byte = id[15:8];
            2'd2:    id_byte = id[7:0];
            default: id_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_if.sv
// SPI pins and backing-store port of the flash responder.
interface spi_flash_if;
    import spi_flash_pkg::*;

    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_rdata;
    logic              busy;
    logic              cmd_err;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, mem_rdata,
        output spi_miso, spi_miso_oe, mem_req, mem_addr, busy, cmd_err
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, mem_rdata,
        input  spi_miso, spi_miso_oe, mem_req, mem_addr, busy, cmd_err
    );
endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with edge detection
// on the synchronized level.
module spi_in_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level  = r_sync[STAGES-1];
    assign o_rise_c = r_sync[STAGES-1] & ~r_prev;
    assign o_fall_c = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_flash_resp.sv
// SPI mode-0 flash responder: READ from a backing store with prefetch,
// RDID and RDSR, oversampled on sys_clk.
module spi_flash_resp
    import spi_flash_pkg::*;
#(
    parameter logic [23:0]       JEDEC_ID    = 24'h20BA18,
    parameter logic [BYTE_W-1:0] STATUS_VAL  = 8'h00,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    spi_flash_if.slave   bus
);

    logic w_sclk, w_sclk_rise, w_sclk_fall;
    logic w_cs, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused_edges;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(sys_clk), .rst_n(rst_n), .i_d(bus.spi_sclk),
        .o_level(w_sclk), .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(sys_clk), .rst_n(rst_n), .i_d(bus.spi_cs_n),
        .o_level(w_cs), .o_rise_c(w_cs_rise), .o_fall_c(w_cs_fall)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(sys_clk), .rst_n(rst_n), .i_d(bus.spi_mosi),
        .o_level(w_mosi), .o_rise_c(w_mosi_rise), .o_fall_c(w_mosi_fall)
    );

    assign w_unused_edges = &{1'b0, w_sclk, w_mosi_rise, w_mosi_fall};

    state_t                r_state, w_state_nxt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [ADDR_W-1:0]     r_shift_in, w_shift_in_nxt;
    logic [BYTE_W-1:0]     r_shift_out, w_shift_out_nxt;
    logic [1:0]            r_id_idx, w_id_idx_nxt;
    logic [ADDR_W-1:0]     r_mem_addr, w_mem_addr_nxt;
    logic                  r_mem_req, w_mem_req_nxt;
    logic                  r_req_d;
    logic                  r_miso, w_miso_nxt;
    logic                  r_oe, w_oe_nxt;
    logic                  r_busy;
    logic                  r_cmd_err, w_cmd_err_nxt;

    logic [ADDR_W-1:0]     w_shift_in_sh;
    logic                  w_byte_done;

    assign w_shift_in_sh = {r_shift_in[ADDR_W-2:0], w_mosi};
    assign w_byte_done   = w_sclk_rise && (r_bit_cnt[2:0] == 3'd7);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_id_idx    <= '0;
            r_mem_addr  <= '0;
            r_mem_req   <= 1'b0;
            r_req_d     <= 1'b0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift_in  <= w_shift_in_nxt;
            r_shift_out <= w_shift_out_nxt;
            r_id_idx    <= w_id_idx_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_req_d     <= r_mem_req;
            r_miso      <= w_miso_nxt;
            r_oe        <= w_oe_nxt;
            r_busy      <= ~w_cs;
            r_cmd_err   <= w_cmd_err_nxt;
        end
    end

    // Chip-select rise outranks any sclk edge seen in the same cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_in_nxt  = r_shift_in;
        w_shift_out_nxt = r_shift_out;
        w_id_idx_nxt    = r_id_idx;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_req_nxt   = 1'b0;
        w_cmd_err_nxt   = 1'b0;
        w_miso_nxt      = r_miso;

        if (w_cs_rise) begin
            w_state_nxt     = ST_IDLE;
            w_bit_cnt_nxt   = '0;
            w_shift_in_nxt  = '0;
            w_shift_out_nxt = '0;
            w_id_idx_nxt    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_nxt    = ST_CMD;
                        w_bit_cnt_nxt  = '0;
                        w_shift_in_nxt = '0;
                    end
                end
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        w_shift_in_nxt = w_shift_in_sh;
                        w_bit_cnt_nxt  = r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == BIT_CNT_W'(7)) begin
                            w_bit_cnt_nxt = '0;
                            case (w_shift_in_sh[BYTE_W-1:0])
                                OP_READ: w_state_nxt = ST_ADDR;
                                OP_RDID: begin
                                    w_state_nxt     = ST_ID;
                                    w_shift_out_nxt = id_byte(JEDEC_ID, 2'd0);
                                    w_id_idx_nxt    = 2'd1;
                                end
                                OP_RDSR: begin
                                    w_state_nxt     = ST_STAT;
                                    w_shift_out_nxt = STATUS_VAL;
                                end
                                default: begin
                                    w_state_nxt   = ST_IGNORE;
                                    w_cmd_err_nxt = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_sclk_rise) begin
                        w_shift_in_nxt = w_shift_in_sh;
                        w_bit_cnt_nxt  = r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == BIT_CNT_W'(ADDR_W - 1)) begin
                            w_bit_cnt_nxt  = '0;
                            w_mem_addr_nxt = w_shift_in_sh;
                            w_mem_req_nxt  = 1'b1;
                            w_state_nxt    = ST_DATA;
                        end
                    end
                end
                ST_DATA, ST_ID, ST_STAT: begin
                    // Store byte lands two cycles after the request, well before the next sclk fall.
                    if (r_state == ST_DATA && r_req_d) begin
                        w_shift_out_nxt = bus.mem_rdata;
                    end
                    if (w_sclk_fall) begin
                        w_miso_nxt      = r_shift_out[BYTE_W-1];
                        w_shift_out_nxt = {r_shift_out[BYTE_W-2:0], 1'b0};
                    end
                    if (w_sclk_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        if (w_byte_done) begin
                            w_bit_cnt_nxt = '0;
                            if (r_state == ST_DATA) begin
                                w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
                                w_mem_req_nxt  = 1'b1;
                            end else if (r_state == ST_ID) begin
                                w_shift_out_nxt = id_byte(JEDEC_ID, r_id_idx);
                                if (r_id_idx != 2'd3) begin
                                    w_id_idx_nxt = r_id_idx + 2'd1;
                                end
                            end else begin
                                w_shift_out_nxt = STATUS_VAL;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        w_oe_nxt = (w_state_nxt == ST_DATA) || (w_state_nxt == ST_ID) || (w_state_nxt == ST_STAT);
        if (!w_oe_nxt) begin
            w_miso_nxt = 1'b0;
        end
    end

    assign bus.spi_miso    = r_miso;
    assign bus.spi_miso_oe = r_oe;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.busy        = r_busy;
    assign bus.cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: READ, address wrap, RDID, bad opcode,
// aborted READ followed by RDSR, and reset during a data phase.
module tb_spi_flash_resp;
    import spi_flash_pkg::*;

    logic sys_clk = 1'b0;
    logic rst_n;

    always #5 sys_clk = ~sys_clk;

    spi_flash_if bus();

    spi_flash_resp #(
        .JEDEC_ID(24'h20BA18),
        .STATUS_VAL(8'h00),
        .SYNC_STAGES(2)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [7:0]  mem [0:255];
    int          n_vec = 0;
    int          n_err = 0;
    int          req_cnt = 0;
    int          err_pulses = 0;
    int          oe_cycles = 0;
    logic [23:0] req_addr [$];

    // Backing store answers one sys_clk after each request.
    always @(posedge sys_clk) begin
        if (bus.mem_req) begin
            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
            req_cnt++;
            req_addr.push_back(bus.mem_addr);
        end
        if (bus.cmd_err) err_pulses++;
        if (bus.spi_miso_oe) oe_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shifts the top nbits of tx out MSB first; rx collects miso just before each rise.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spi_mosi = tx[i];
            #80;
            rx[i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            #80;
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #80;
        bus.spi_cs_n = 1'b1;
        #200;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr);
        logic [7:0] rx;
        spi_byte(op, 8, rx);
        spi_byte(addr[23:16], 8, rx);
        spi_byte(addr[15:8], 8, rx);
        spi_byte(addr[7:0], 8, rx);
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] exp_rd [4];
        logic [7:0] exp_id [4];
        int base;
        int e0;
        int o0;

        exp_rd[0] = 8'hA5; exp_rd[1] = 8'h5A; exp_rd[2] = 8'hC3; exp_rd[3] = 8'h3C;
        exp_id[0] = 8'h20; exp_id[1] = 8'hBA; exp_id[2] = 8'h18; exp_id[3] = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5; mem[8'h11] = 8'h5A; mem[8'h12] = 8'hC3; mem[8'h13] = 8'h3C;
        mem[8'hFF] = 8'h77; mem[8'h00] = 8'h88;

        rst_n        = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        repeat (3) @(negedge sys_clk);

        check("rst_miso",     32'(bus.spi_miso),    32'h0);
        check("rst_oe",       32'(bus.spi_miso_oe), 32'h0);
        check("rst_mem_req",  32'(bus.mem_req),     32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr),    32'h0);
        check("rst_busy",     32'(bus.busy),        32'h0);
        check("rst_cmd_err",  32'(bus.cmd_err),     32'h0);

        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("idle_busy", 32'(bus.busy), 32'h0);

        // READ 0x000010, four bytes; last completion also prefetches 0x14
        base = req_cnt;
        cs_low();
        check("read_busy", 32'(bus.busy), 32'h1);
        send_hdr(8'h03, 24'h000010);
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'h00, 8, rx);
            check($sformatf("read_byte%0d", k), 32'(rx), 32'(exp_rd[k]));
        end
        check("read_oe", 32'(bus.spi_miso_oe), 32'h1);
        cs_high();
        check("read_end_oe",   32'(bus.spi_miso_oe), 32'h0);
        check("read_end_miso", 32'(bus.spi_miso),    32'h0);
        check("read_end_busy", 32'(bus.busy),        32'h0);
        check("read_req_cnt",  32'(req_cnt - base),  32'd5);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("read_addr%0d", k), 32'(req_addr[base + k]), 32'h10 + 32'(k));
        end

        // READ at the top of the address space wraps to zero
        base = req_cnt;
        cs_low();
        send_hdr(8'h03, 24'hFFFFFF);
        spi_byte(8'h00, 8, rx);
        check("wrap_byte0", 32'(rx), 32'h77);
        spi_byte(8'h00, 8, rx);
        check("wrap_byte1", 32'(rx), 32'h88);
        cs_high();
        check("wrap_addr0",   32'(req_addr[base]),     32'hFFFFFF);
        check("wrap_addr1",   32'(req_addr[base + 1]), 32'h000000);
        check("wrap_req_cnt", 32'(req_cnt - base),     32'd3);

        // RDID with one byte past the identification
        base = req_cnt;
        cs_low();
        spi_byte(8'h9F, 8, rx);
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'h00, 8, rx);
            check($sformatf("rdid_byte%0d", k), 32'(rx), 32'(exp_id[k]));
        end
        cs_high();
        check("rdid_no_req", 32'(req_cnt - base), 32'd0);

        // Unsupported opcode
        base = req_cnt;
        e0   = err_pulses;
        o0   = oe_cycles;
        cs_low();
        spi_byte(8'hAB, 8, rx);
        spi_byte(8'hFF, 8, rx);
        check("bad_miso", 32'(rx), 32'h0);
        cs_high();
        check("bad_err_pulses", 32'(err_pulses - e0), 32'd1);
        check("bad_oe_cycles",  32'(oe_cycles - o0),  32'd0);
        check("bad_no_req",     32'(req_cnt - base),  32'd0);

        // READ aborted after 12 address bits, then RDSR
        base = req_cnt;
        cs_low();
        spi_byte(8'h03, 8, rx);
        spi_byte(8'h12, 8, rx);
        spi_byte(8'h34, 4, rx);
        cs_high();
        check("abort_no_req", 32'(req_cnt - base), 32'd0);
        o0 = oe_cycles;
        cs_low();
        spi_byte(8'h05, 8, rx);
        spi_byte(8'h00, 8, rx);
        check("rdsr_byte0", 32'(rx), 32'h00);
        spi_byte(8'h00, 8, rx);
        check("rdsr_byte1", 32'(rx), 32'h00);
        check("rdsr_oe_seen", 32'(oe_cycles > o0), 32'h1);
        cs_high();
        check("rdsr_no_req", 32'(req_cnt - base), 32'd0);

        // Reset pulsed in the middle of a data byte
        cs_low();
        send_hdr(8'h03, 24'h000010);
        spi_byte(8'h00, 8, rx);
        check("pre_rst_byte", 32'(rx), 32'hA5);
        spi_byte(8'h00, 3, rx);
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso",     32'(bus.spi_miso),    32'h0);
        check("mid_rst_oe",       32'(bus.spi_miso_oe), 32'h0);
        check("mid_rst_mem_req",  32'(bus.mem_req),     32'h0);
        check("mid_rst_mem_addr", 32'(bus.mem_addr),    32'h0);
        check("mid_rst_busy",     32'(bus.busy),        32'h0);
        check("mid_rst_cmd_err",  32'(bus.cmd_err),     32'h0);
        @(negedge sys_clk);
        bus.spi_cs_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("post_rst_busy", 32'(bus.busy), 32'h0);

        cs_low();
        spi_byte(8'h9F, 8, rx);
        for (int k = 0; k < 3; k++) begin
            spi_byte(8'h00, 8, rx);
            check($sformatf("post_rst_rdid%0d", k), 32'(rx), 32'(exp_id[k]));
        end
        cs_high();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
